comm_host: RTL

//  Host-side initiator for the console-mux serial command protocol.

---
 rtl/comm_pkg.sv | 40 ++++
 rtl/uart_rx.sv | 68 ++++++
 rtl/uart_tx.sv | 55 +++++
 rtl/comm_host.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the console-mux command host: opcodes, per-opcode
// byte counts and FSM state encodings.
package comm_pkg;

   localparam logic [2:0] COMM_READ_ENABLE_MASK  = 3'b001;
   localparam logic [2:0] COMM_READ_PIN_MAP      = 3'b010;
   localparam logic [2:0] COMM_WRITE_ENABLE_MASK = 3'b011;
   localparam logic [2:0] COMM_WRITE_PIN_MAP     = 3'b100;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_TX_LOAD = 3'd1;
   localparam logic [2:0] ST_TX_WAIT = 3'd2;
   localparam logic [2:0] ST_RX_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   function automatic logic cmd_ok(input logic [2:0] cmd);
      return (cmd == COMM_READ_ENABLE_MASK) || (cmd == COMM_READ_PIN_MAP) ||
             (cmd == COMM_WRITE_ENABLE_MASK) || (cmd == COMM_WRITE_PIN_MAP);
   endfunction

   // Total bytes sent on TX, command byte included.
   function automatic logic [2:0] tx_bytes(input logic [2:0] cmd);
      case (cmd)
         COMM_READ_ENABLE_MASK:  return 3'd1;
         COMM_READ_PIN_MAP:      return 3'd1;
         COMM_WRITE_ENABLE_MASK: return 3'd3;
         COMM_WRITE_PIN_MAP:     return 3'd5;
         default:                return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] rx_bytes(input logic [2:0] cmd);
      case (cmd)
         COMM_READ_ENABLE_MASK: return 3'd2;
         COMM_READ_PIN_MAP:     return 3'd4;
         default:               return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver. rx_ready rises when a well-framed byte lands in rx_data
// and stays high until the next start bit is seen.
module uart_rx #(
   parameter int CLOCK_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial_line,
   output logic [7:0] rx_data,
   output logic       rx_ready
);
   localparam int CW = $clog2(CLOCK_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF = CW'(CLOCK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLOCK_PER_BIT - 1);

   logic [1:0]    sync;
   logic [1:0]    phase;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync     <= 2'b11;
         phase    <= 2'd0;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_ready <= 1'b0;
      end else begin
         sync <= {sync[0], rx_serial_line};
         case (phase)
            2'd0: if (!sync[1]) begin
               phase    <= 2'd1;
               clk_cnt  <= '0;
               rx_ready <= 1'b0;
            end
            // Re-check the start bit at its middle to reject glitches.
            2'd1: if (clk_cnt == HALF) begin
               clk_cnt <= '0;
               bit_idx <= '0;
               phase   <= sync[1] ? 2'd0 : 2'd2;
            end else begin
               clk_cnt <= clk_cnt + CW'(1);
            end
            2'd2: if (clk_cnt == FULL) begin
               clk_cnt <= '0;
               shreg   <= {sync[1], shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == 3'd7) phase <= 2'd3;
            end else begin
               clk_cnt <= clk_cnt + CW'(1);
            end
            default: if (clk_cnt == FULL) begin
               phase <= 2'd0;
               if (sync[1]) begin
                  rx_data  <= shreg;
                  rx_ready <= 1'b1;
               end
            end else begin
               clk_cnt <= clk_cnt + CW'(1);
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. No reset: state zero is idle, and tx_done is high
// only while idle, so a new byte is taken only after the current frame ends.
module uart_tx #(
   parameter int CLOCK_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       tx_data_ready,
   input  logic [7:0] tx_data,
   output logic       tx_serial_line,
   output logic       tx_done
);
   localparam int CW = $clog2(CLOCK_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL = CW'(CLOCK_PER_BIT - 1);

   logic [1:0]    phase;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   always_ff @(posedge clk) begin
      if (phase == 2'd0) begin
         if (tx_data_ready) begin
            shreg   <= tx_data;
            phase   <= 2'd1;
            clk_cnt <= '0;
            bit_idx <= '0;
         end
      end else if (clk_cnt == FULL) begin
         clk_cnt <= '0;
         if (phase == 2'd1) begin
            phase <= 2'd2;
         end else if (phase == 2'd2) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) phase <= 2'd3;
         end else begin
            phase <= 2'd0;
         end
      end else begin
         clk_cnt <= clk_cnt + CW'(1);
      end
   end

   assign tx_done = (phase == 2'd0);

   always_comb begin
      tx_serial_line = 1'b1;
      case (phase)
         2'd1:    tx_serial_line = 1'b0;
         2'd2:    tx_serial_line = shreg[0];
         default: tx_serial_line = 1'b1;
      endcase
   end

endmodule

// File: rtl/comm_host.sv
// Host-side initiator for the console-mux command protocol: sends the command
// byte and write payload, gathers reply bytes, reports done/error.
module comm_host
   import comm_pkg::*;
#(
   parameter int CLOCK_PER_BIT  = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_cmd,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        tx_serial_line,
   input  logic        rx_serial_line
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    state;
   logic [2:0]    cmd_q;
   logic [31:0]   wdata_q;
   logic [31:0]   data_q;
   logic          err_q;
   logic [2:0]    tx_idx;
   logic [2:0]    rx_cnt;
   logic          seen_low;
   logic [TW-1:0] tmo_cnt;
   logic          rx_ready_q;

   logic       tx_data_ready;
   logic [7:0] tx_data;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_strobe;

   // Request handshake: a transfer happens on a clk edge where req_valid and
   // req_ready are both high; req_cmd/req_wdata are captured on that edge.
   // req_ready is high only in IDLE with the transmitter idle.
   assign req_ready = (state == ST_IDLE) && tx_done;
   assign busy      = !req_ready;
   assign rsp_valid = (state == ST_DONE);
   assign rsp_err   = (state == ST_DONE) && err_q;
   assign rsp_data  = data_q;

   assign tx_data_ready = (state == ST_TX_LOAD);
   assign rx_strobe     = rx_ready && !rx_ready_q;

   always_comb begin
      tx_data = 8'h00;
      case (tx_idx)
         3'd0:    tx_data = {5'b0, cmd_q};
         3'd1:    tx_data = wdata_q[7:0];
         3'd2:    tx_data = wdata_q[15:8];
         3'd3:    tx_data = wdata_q[23:16];
         3'd4:    tx_data = wdata_q[31:24];
         default: tx_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cmd_q      <= '0;
         wdata_q    <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         tx_idx     <= '0;
         rx_cnt     <= '0;
         seen_low   <= 1'b0;
         tmo_cnt    <= '0;
         rx_ready_q <= 1'b0;
      end else begin
         rx_ready_q <= rx_ready;
         case (state)
            ST_IDLE: if (req_valid && req_ready) begin
               cmd_q   <= req_cmd;
               wdata_q <= req_wdata;
               data_q  <= '0;
               tx_idx  <= '0;
               rx_cnt  <= '0;
               tmo_cnt <= '0;
               err_q   <= !cmd_ok(req_cmd);
               state   <= cmd_ok(req_cmd) ? ST_TX_LOAD : ST_DONE;
            end
            ST_TX_LOAD: begin
               seen_low <= 1'b0;
               state    <= ST_TX_WAIT;
            end
            // A byte is finished once tx_done has dropped and come back.
            ST_TX_WAIT: if (!tx_done) begin
               seen_low <= 1'b1;
            end else if (seen_low) begin
               tx_idx <= tx_idx + 3'd1;
               if (tx_idx + 3'd1 < tx_bytes(cmd_q)) begin
                  state <= ST_TX_LOAD;
               end else if (rx_bytes(cmd_q) != 3'd0) begin
                  tmo_cnt <= '0;
                  state   <= ST_RX_WAIT;
               end else begin
                  state <= ST_DONE;
               end
            end
            ST_RX_WAIT: if (rx_strobe) begin
               data_q[{rx_cnt[1:0], 3'b000} +: 8] <= rx_data;
               rx_cnt  <= rx_cnt + 3'd1;
               tmo_cnt <= '0;
               if (rx_cnt + 3'd1 == rx_bytes(cmd_q)) state <= ST_DONE;
            end else if (tmo_cnt == TMO_LAST) begin
               err_q <= 1'b1;
               state <= ST_DONE;
            end else begin
               tmo_cnt <= tmo_cnt + TW'(1);
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_tx #(.CLOCK_PER_BIT(CLOCK_PER_BIT)) u_uart_tx (
      .clk            (clk),
      .tx_data_ready  (tx_data_ready),
      .tx_data        (tx_data),
      .tx_serial_line (tx_serial_line),
      .tx_done        (tx_done)
   );

   uart_rx #(.CLOCK_PER_BIT(CLOCK_PER_BIT)) u_uart_rx (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_serial_line (rx_serial_line),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready)
   );

endmodule
